// File: rtl/generic_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : generic_counter
// Description : Free-running CNT_WIDTH-bit binary up-counter (DAC ramp code).
// Revision    : 1.0 - initial release
// ============================================================================
module generic_counter #(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_cnt;

  // Sum is kept at CNT_WIDTH bits so the all-ones value wraps to zero naturally.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_one;
    end
  end

  assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_generic_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_generic_counter
// Description : Self-checking bench for generic_counter at widths 1, 3, 4, 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_generic_counter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [0:0] cnt1;
  logic [2:0] cnt3;
  logic [3:0] cnt4;
  logic [7:0] cnt8;

  int n_checks = 0;
  int n_pass   = 0;

  generic_counter #(.CNT_WIDTH(1)) u_dut_w1 (.clk_i(clk), .rst_n_i(rst_n), .cnt_o(cnt1));
  generic_counter #(.CNT_WIDTH(3)) u_dut_w3 (.clk_i(clk), .rst_n_i(rst_n), .cnt_o(cnt3));
  generic_counter #(.CNT_WIDTH(4)) u_dut_w4 (.clk_i(clk), .rst_n_i(rst_n), .cnt_o(cnt4));
  generic_counter #(.CNT_WIDTH(8)) u_dut_w8 (.clk_i(clk), .rst_n_i(rst_n), .cnt_o(cnt8));

  initial forever #5 clk = ~clk;

  // Reference: number of rising edges seen with reset released; count = edges mod 2**W.
  int unsigned edges = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges = 0;
    else        edges = edges + 1;
  end

  function automatic logic [31:0] model(input int w);
    return edges % (32'd1 << w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    else
      n_pass++;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_w1"}, {31'd0, cnt1}, model(1));
    check({tag, "_w3"}, {29'd0, cnt3}, model(3));
    check({tag, "_w4"}, {28'd0, cnt4}, model(4));
    check({tag, "_w8"}, {24'd0, cnt8}, model(8));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_w1"}, {31'd0, cnt1}, 32'd0);
    check({tag, "_w3"}, {29'd0, cnt3}, 32'd0);
    check({tag, "_w4"}, {28'd0, cnt4}, 32'd0);
    check({tag, "_w8"}, {24'd0, cnt8}, 32'd0);
  endtask

  typedef struct {
    bit       rst_n_next;
    int       exp3;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit found;

    // Ramp and wrap for the 3-bit counter, sampled from t=20 onward.
    for (int i = 0; i < 16; i++) tbl.push_back('{rst_n_next: 1'b1, exp3: i % 8});

    // Asynchronous reset between rising edges.
    @(negedge clk);          // t=10
    rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);          // t=20
    check_zero("reset_low_t20");

    // Table-driven ramp: release at t=20, samples read 0..7,0..7.
    foreach (tbl[i]) begin
      check($sformatf("ramp_%0d", i), {29'd0, cnt3}, tbl[i].exp3);
      rst_n = tbl[i].rst_n_next;
      @(negedge clk);
    end

    // Mid-count reset at value 5, bounded wait.
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (cnt3 == 3'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("wait_cnt5", {31'd0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("midcount_async");

    // Reset held across five rising edges.
    repeat (5) begin
      @(negedge clk);
      check_zero("reset_hold");
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("after_release_%0d", i), {29'd0, cnt3}, i);
    end

    // Width sweep: full 8-bit cycle plus wrap, all widths against the model.
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("sweep_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 260; i++) begin
      check_all("sweep");
      if (i == 256) check("w8_wrap", {24'd0, cnt8}, 32'd0);
      @(negedge clk);
    end

    // Randomized reset pulses at random offsets within the low clock phase.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check_all("rand");
      if ($urandom_range(0, 9) == 0) begin
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1 check_zero("rand_async");
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          check_zero("rand_hold");
        end
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
